// File: rtl/pitch_pkg.sv
// pitch_pkg: shared word/enable types and output FSM states for the PITCH UDP packer
package pitch_pkg;
  localparam int BYTES_PER_WORD = 8;
  typedef logic [63:0] word_t;
  typedef logic [7:0] be_t;
  typedef enum logic [1:0] {IDLE, SEND, GAP} out_state_t;
endpackage

// File: rtl/pitch_udp_word_packer_accumulator.sv
// pitch_byte_accumulator: packs accepted bytes MSB-first into one word with byte enables
module pitch_byte_accumulator
  import pitch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_byte,
  input  logic       accept,
  input  logic       s_last,
  input  logic       take,
  output word_t      word,
  output be_t        be,
  output logic       full,
  output logic       last
);
  logic [3:0] idx;
  logic [2:0] wi;
  // a byte accepted while the finished word leaves starts the fresh word at lane 0
  assign wi = take ? 3'd0 : idx[2:0];
  assign full = idx == 4'(BYTES_PER_WORD) || last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      word <= '0;
      be <= '0;
      idx <= '0;
      last <= 1'b0;
    end else begin
      if (take) begin
        word <= '0;
        be <= '0;
        idx <= '0;
        last <= 1'b0;
      end
      if (accept) begin
        word[{~wi, 3'b000} +: 8] <= s_byte;
        be[~wi] <= 1'b1;
        idx <= {1'b0, wi} + 4'd1;
        last <= s_last;
      end
    end
endmodule

// File: rtl/pitch_udp_word_packer.sv
// pitch_udp_word_packer: byte stream to 64-bit parser words with datagram gap and counters
module pitch_udp_word_packer
  import pitch_pkg::*;
#(
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 32
) (
  input  logic             Clk40,
  input  logic             reset_n,
  input  logic [7:0]       s_byte,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output word_t            out_bytes,
  output be_t              out_byte_enables,
  output logic             out_data_valid,
  input  logic             in_ready_for_udp,
  output logic [CNT_W-1:0] datagram_count,
  output logic [CNT_W-1:0] word_count
);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  word_t acc_word;
  be_t acc_be;
  logic acc_full, acc_last, accept, take, xfer, can_take;
  logic hold_v, hold_nx, hold_last, ready_en;
  logic [GW-1:0] gap_cnt;
  logic [CNT_W-1:0] word_cnt, dg_cnt;
  out_state_t state, state_nx;
  pitch_byte_accumulator u_acc (
    .clk(Clk40), .rst_n(reset_n), .s_byte(s_byte), .accept(accept), .s_last(s_last),
    .take(take), .word(acc_word), .be(acc_be), .full(acc_full), .last(acc_last)
  );
  assign out_data_valid = state == SEND;
  assign xfer = out_data_valid && in_ready_for_udp;
  assign can_take = !hold_v || xfer;
  assign take = acc_full && can_take;
  assign hold_nx = take || (hold_v && !xfer);
  assign s_ready = ready_en && (!acc_full || (can_take && state != GAP));
  assign accept = s_valid && s_ready;
  assign word_count = word_cnt;
  assign datagram_count = dg_cnt;
  always_comb begin
    state_nx = hold_nx ? SEND : IDLE;
    if (state == GAP)
      state_nx = gap_cnt == GW'(GAP_CYCLES - 1) ? (hold_nx ? SEND : IDLE) : GAP;
    else if (xfer && hold_last)
      state_nx = GAP;
  end
  always_ff @(posedge Clk40 or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      gap_cnt <= '0;
      hold_v <= 1'b0;
      hold_last <= 1'b0;
      out_bytes <= '0;
      out_byte_enables <= '0;
      word_cnt <= '0;
      dg_cnt <= '0;
      ready_en <= 1'b0;
    end else begin
      state <= state_nx;
      gap_cnt <= state == GAP ? gap_cnt + 1'b1 : '0;
      hold_v <= hold_nx;
      if (take) begin
        out_bytes <= acc_word;
        out_byte_enables <= acc_be;
        hold_last <= acc_last;
      end
      word_cnt <= word_cnt + CNT_W'(xfer);
      dg_cnt <= dg_cnt + CNT_W'(xfer && hold_last);
      ready_en <= 1'b1;
    end
endmodule

// File: tb/tb_pitch_udp_word_packer.sv
// tb_pitch_udp_word_packer: directed scoreboard bench for the PITCH UDP word packer
module tb_pitch_udp_word_packer;
  localparam int GAP = 1;
  typedef struct {
    logic [63:0] w;
    logic [7:0]  be;
    bit          last;
  } exp_t;

  logic Clk40 = 0, reset_n = 0, s_valid = 0, s_last = 0, s_ready, out_data_valid;
  logic in_ready_for_udp = 1;
  logic [7:0] s_byte = 0, out_byte_enables;
  logic [63:0] out_bytes;
  logic [31:0] datagram_count, word_count, exp_wc = 0, exp_dg = 0;
  exp_t q[$];
  int checks = 0, errors = 0, idle = 0;
  bit gap_pend = 0, saw_block = 0;
  logic [7:0] d[$];

  pitch_udp_word_packer #(.GAP_CYCLES(GAP), .CNT_W(32)) dut (
    .Clk40(Clk40), .reset_n(reset_n), .s_byte(s_byte), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .out_bytes(out_bytes), .out_byte_enables(out_byte_enables),
    .out_data_valid(out_data_valid), .in_ready_for_udp(in_ready_for_udp),
    .datagram_count(datagram_count), .word_count(word_count)
  );

  always #5 Clk40 = ~Clk40;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic send(input logic [7:0] b[$], input bit last);
    logic [63:0] w = 0;
    logic [7:0] be = 0;
    int n = 0, i = 0, stall = 0;
    bit acc;
    for (int k = 0; k < b.size(); k++) begin
      w[63-8*n -: 8] = b[k];
      be[7-n] = 1'b1;
      n++;
      if (n == 8 || (last && k == b.size() - 1)) begin
        q.push_back('{w, be, last && k == b.size() - 1});
        exp_wc++;
        if (last && k == b.size() - 1) exp_dg++;
        w = 0;
        be = 0;
        n = 0;
      end
    end
    while (i < b.size() && stall < 1000) begin
      s_byte = b[i];
      s_valid = 1;
      s_last = last && i == b.size() - 1;
      @(negedge Clk40);
      acc = s_ready;
      @(posedge Clk40);
      #1;
      if (acc) i++;
      else stall++;
    end
    s_valid = 0;
    s_last = 0;
    chk("send_complete", i, b.size());
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || out_data_valid) && n < 500) begin
      @(posedge Clk40);
      #1;
      n++;
    end
    chk("drain_queue_empty", q.size(), 0);
    repeat (3) @(posedge Clk40);
    #1;
    chk("word_count", word_count, exp_wc);
    chk("datagram_count", datagram_count, exp_dg);
  endtask

  initial forever begin
    @(negedge Clk40);
    if (reset_n && s_valid && !s_ready) saw_block = 1;
    if (reset_n && out_data_valid) begin
      chk("word_expected", q.size() != 0, 1);
      if (gap_pend) chk("gap_cycles_met", idle >= GAP, 1);
      gap_pend = 0;
      if (q.size() != 0) begin
        chk("out_bytes", out_bytes, q[0].w);
        chk("out_byte_enables", out_byte_enables, q[0].be);
        if (in_ready_for_udp) begin
          if (q[0].last) begin
            gap_pend = 1;
            idle = 0;
          end
          void'(q.pop_front());
        end
      end
    end else if (gap_pend) idle++;
  end

  initial begin
    #2;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_valid", out_data_valid, 0);
    chk("rst_bytes", out_bytes, 0);
    chk("rst_be", out_byte_enables, 0);
    chk("rst_words", word_count, 0);
    chk("rst_dgrams", datagram_count, 0);
    repeat (3) @(negedge Clk40);
    reset_n = 1;
    @(posedge Clk40);
    #1;
    chk("s_ready_after_reset", s_ready, 1);

    d = '{8'h0e, 8'h00, 8'h01, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00,
          8'h06, 8'h20, 8'h19, 8'hd2, 8'h06, 8'h00};
    send(d, 1);
    drain();

    for (int j = 0; j < 2; j++) begin
      d = {};
      for (int i = 0; i < 16; i++) d.push_back(8'(8'h40 + 16 * j + i));
      send(d, 1);
    end
    drain();

    d = '{8'hab};
    send(d, 1);
    drain();

    d = {};
    for (int i = 0; i < 24; i++) d.push_back(8'(8'h80 + i));
    saw_block = 0;
    fork
      send(d, 1);
      begin
        repeat (3) @(posedge Clk40);
        #1;
        in_ready_for_udp = 0;
        repeat (20) @(posedge Clk40);
        #1;
        in_ready_for_udp = 1;
      end
    join
    drain();
    chk("s_ready_dropped_in_stall", saw_block, 1);

    d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send(d, 0);
    #2;
    reset_n = 0;
    #1;
    chk("midrst_valid", out_data_valid, 0);
    chk("midrst_bytes", out_bytes, 0);
    chk("midrst_be", out_byte_enables, 0);
    chk("midrst_s_ready", s_ready, 0);
    chk("midrst_words", word_count, 0);
    exp_wc = 0;
    exp_dg = 0;
    repeat (3) @(negedge Clk40);
    reset_n = 1;
    @(posedge Clk40);
    #1;
    d = '{8'hc0, 8'hc1, 8'hc2, 8'hc3, 8'hc4, 8'hc5, 8'hc6, 8'hc7};
    send(d, 1);
    drain();

    @(negedge Clk40);
    force dut.word_cnt = 32'hffff_ffff;
    #1;
    release dut.word_cnt;
    #1;
    chk("word_count_preload", word_count, 32'hffff_ffff);
    exp_wc = 32'hffff_ffff;
    @(posedge Clk40);
    #1;
    d = '{8'h5a};
    send(d, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
